softmax_max_sub_scale: RTL

Upstream pre-processing stage of the non-pipelined softmax datapath. It buffers one vector of N signed Q4.12 logits and finds the vector maximum. It then streams (x_i - max) * log2(e) in Q4.12, which is the exponent fed directly to the pow2_approx stage. All outputs are <= 0, so the downstream 2^x stays in (0, 1].

---
 rtl/softmax_max_sub_scale.sv | 103 ++++++++++
 1 files changed

// File: rtl/softmax_max_sub_scale.sv
// Softmax front end: buffers one vector of N Q4.12 logits, tracks the maximum,
// then streams (x_i - max) * log2(e) in Q4.12 as the pow2 stage's exponent.
module softmax_max_sub_scale #(
  parameter int unsigned N     = 8,
  parameter logic [15:0] LOG2E = 16'h1715
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_last,
  output logic        busy
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    LOAD,
    EMIT
  } state_t;

  state_t             state;
  logic [15:0]        buf_mem [N];
  logic signed [15:0] max_reg;
  logic [CW-1:0]      cnt;
  logic [CW-1:0]      idx;

  logic               in_hs;
  logic               out_hs;
  logic [15:0]        cur_x;
  logic signed [16:0] diff;
  logic signed [32:0] prod;
  logic signed [32:0] res;

  assign in_ready  = (state == LOAD) && !rst;
  assign out_valid = (state == EMIT);
  assign busy      = (state == EMIT);
  assign out_last  = (state == EMIT) && (idx == CW'(N - 1));
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= LOAD;
      cnt     <= '0;
      idx     <= '0;
      max_reg <= 16'sh8000;
    end else begin
      case (state)
        LOAD: begin
          if (in_hs) begin
            // First element re-seeds the maximum, so stale buffer data never leaks in.
            if (cnt == '0 || $signed(in_data) > max_reg)
              max_reg <= $signed(in_data);
            if (cnt == CW'(N - 1)) begin
              cnt   <= '0;
              idx   <= '0;
              state <= EMIT;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        EMIT: begin
          if (out_hs) begin
            if (idx == CW'(N - 1)) begin
              idx   <= '0;
              state <= LOAD;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (in_hs)
      buf_mem[cnt] <= in_data;
  end

  // diff is never positive, so only the negative saturation bound is needed.
  always_comb begin
    cur_x    = buf_mem[idx];
    diff     = $signed({cur_x[15], cur_x}) - $signed({max_reg[15], max_reg});
    prod     = $signed({{16{diff[16]}}, diff}) * $signed({17'd0, LOG2E});
    res      = prod >>> 12;
    out_data = '0;
    if (state == EMIT) begin
      if (res < -33'sd32768)
        out_data = 16'h8000;
      else
        out_data = res[15:0];
    end
  end

endmodule
